// File: rtl/vl_pipe_pkg.sv
// vl_pipe_pkg: shared constants and helpers for the vl_pipe family
package vl_pipe_pkg;
  localparam int FIFO_DEPTH_MIN = 2;
  localparam int FIFO_DEPTH_MAX = 64;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction
  function automatic bit fifo_depth_ok(input int d);
    return d >= FIFO_DEPTH_MIN && d <= FIFO_DEPTH_MAX;
  endfunction
endpackage

// File: rtl/vl_pipe_sink_fifo.sv
// vl_pipe_sink_fifo: receive buffer with registered head output and drop detect
module vl_pipe_sink_fifo
  import vl_pipe_pkg::*;
#(
  parameter int DW    = 1,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          drop
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  logic [CW-1:0] cnt;
  logic          full, pop_ok, push_ok;
  assign empty   = cnt == '0;
  assign full    = cnt == CW'(DEPTH);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign rd_nxt  = rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
  assign wr_nxt  = wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
  // storage is deliberately left unreset; only control state clears
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;
  // pointers, occupancy and the head register; head loads the next entry on pop
  // or the incoming beat when the buffer is (or becomes) empty, otherwise holds
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      dout   <= '0;
    end else begin
      if (pop_ok) rd_ptr <= rd_nxt;
      if (push_ok) wr_ptr <= wr_nxt;
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
      if (pop_ok && cnt > CW'(1)) dout <= mem[rd_nxt];
      else if ((pop_ok | empty) & push_ok) dout <= din;
    end
endmodule

// File: rtl/vl_pipe_sink.sv
// vl_pipe_sink: credit-based receiver at the end of a fixed-latency pipe
module vl_pipe_sink
  import vl_pipe_pkg::*;
#(
  parameter int PIPE_DEPTH = 1,
  parameter int PIPE_DW    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             issue,
  output logic                             issue_rdy,
  input  logic                             din_vld,
  input  logic [PIPE_DW-1:0]               din,
  output logic                             dout_vld,
  output logic [PIPE_DW-1:0]               dout,
  input  logic                             dout_rdy,
  output logic [clog2(FIFO_DEPTH+1)-1:0]   credits,
  output logic                             ovf_err
);
  localparam int CW = clog2(FIFO_DEPTH + 1);
  if (!fifo_depth_ok(FIFO_DEPTH) || PIPE_DEPTH < 1) begin : g_bad_cfg
    $error("vl_pipe_sink: FIFO_DEPTH must be 2..64 and PIPE_DEPTH >= 1");
  end
  logic empty, drop, issue_ok, ret;
  assign issue_rdy = credits != '0;
  assign dout_vld  = ~empty;
  assign issue_ok  = issue & issue_rdy;
  assign ret       = dout_vld & dout_rdy;
  vl_pipe_sink_fifo #(.DW(PIPE_DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (din_vld),
    .din    (din),
    .pop    (ret),
    .dout   (dout),
    .empty  (empty),
    .drop   (drop)
  );
  // credits track free slots downstream of the sender; error is sticky until reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      credits <= CW'(FIFO_DEPTH);
      ovf_err <= 1'b0;
    end else begin
      credits <= credits - CW'(issue_ok) + CW'(ret);
      if ((issue & ~issue_rdy) | drop) ovf_err <= 1'b1;
    end
endmodule

// File: tb/tb_vl_pipe_sink.sv
// tb_vl_pipe_sink: randomized and directed checks against a queue-based model
module tb_vl_pipe_sink;
  localparam int FD = 4;
  logic       clk, reset_n, issue, issue_rdy, din_vld, dout_vld, dout_rdy, ovf_err;
  logic [7:0] din, dout;
  logic [2:0] credits;
  logic [7:0] q[$];
  int         iss_cyc[$];
  logic [7:0] seen[$];
  int         credit_m, cyc, n_vec, n_bad, acc_cnt, a0;
  bit         ovf_m, track_lat;
  logic [7:0] last_m;
  bit         pv[3];
  logic [7:0] pd[3];

  vl_pipe_sink #(.PIPE_DEPTH(3), .PIPE_DW(8), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .issue(issue), .issue_rdy(issue_rdy),
    .din_vld(din_vld), .din(din), .dout_vld(dout_vld), .dout(dout),
    .dout_rdy(dout_rdy), .credits(credits), .ovf_err(ovf_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    q.delete();
    credit_m = FD;
    ovf_m = 0;
    last_m = 0;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 0;
      pd[i] = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 0;
    issue = 0;
    din_vld = 0;
    din = 0;
    dout_rdy = 0;
    clear_model();
    #1;
    chk("rst_credits", credits, 4);
    chk("rst_issue_rdy", issue_rdy, 1);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf_err, 0);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit iss, input logic [7:0] d, input bit rdy, input bit frc, input logic [7:0] fd);
    bit acc, pop;
    issue = iss;
    dout_rdy = rdy;
    din_vld = frc | pv[2];
    din = frc ? fd : pd[2];
    acc = iss && credit_m != 0;
    if (iss && credit_m == 0) ovf_m = 1;
    pop = rdy && q.size() != 0;
    if (pop) q.delete(0);
    if (din_vld) begin
      if (q.size() < FD) q.push_back(din);
      else ovf_m = 1;
    end
    credit_m += int'(pop) - int'(acc);
    if (acc) begin
      acc_cnt++;
      iss_cyc.push_back(cyc);
    end
    pv[2] = pv[1]; pv[1] = pv[0]; pv[0] = acc;
    pd[2] = pd[1]; pd[1] = pd[0]; pd[0] = d;
    if (q.size() != 0) last_m = q[0];
    @(posedge clk);
    #1;
    cyc++;
    chk("credits", credits, credit_m);
    chk("issue_rdy", issue_rdy, credit_m != 0);
    chk("dout_vld", dout_vld, q.size() != 0);
    chk("dout", dout, last_m);
    chk("ovf_err", ovf_err, ovf_m);
    if (track_lat && dout_vld && iss_cyc.size() != 0) chk("latency", cyc - iss_cyc.pop_front(), 4);
  endtask

  task automatic drain_record(input int n);
    seen.delete();
    for (int i = 0; i < n; i++) begin
      if (dout_vld) seen.push_back(dout);
      step(0, 0, 1, 0, 0);
    end
  endtask

  initial begin
    int v;
    logic [7:0] exp4 [4];
    n_vec = 0; n_bad = 0; cyc = 0; acc_cnt = 0; track_lat = 0;
    reset_n = 1; issue = 0; din_vld = 0; din = 0; dout_rdy = 0;
    clear_model();
    #2;
    do_reset();
    chk("post_rst_credits", credits, 4);
    chk("post_rst_issue_rdy", issue_rdy, 1);
    chk("post_rst_dout_vld", dout_vld, 0);
    chk("post_rst_ovf", ovf_err, 0);

    // streaming 0x01..0x0A with the consumer always ready
    iss_cyc.delete();
    seen.delete();
    track_lat = 1;
    v = 1;
    for (int i = 0; i < 40; i++) begin
      if (v <= 10 && credit_m != 0) begin
        step(1, 8'(v), 1, 0, 0);
        v++;
      end else step(0, 0, 1, 0, 0);
      if (dout_vld) seen.push_back(dout);
    end
    track_lat = 0;
    chk("stream_count", seen.size(), 10);
    for (int i = 0; i < seen.size(); i++) chk("stream_order", seen[i], i + 1);

    // stall: consumer blocked, sender obeys issue_rdy
    a0 = acc_cnt;
    for (int i = 0; i < 12; i++) step(credit_m != 0, 8'(8'h20 + i), 0, 0, 0);
    chk("stall_accepted", acc_cnt - a0, 4);
    chk("stall_issue_rdy", issue_rdy, 0);
    chk("stall_full_vld", dout_vld, 1);
    chk("stall_ovf", ovf_err, 0);
    drain_record(8);
    chk("stall_drain_cnt", seen.size(), 4);
    for (int i = 0; i < seen.size(); i++) chk("stall_drain_order", seen[i], 8'h20 + i);
    chk("stall_credits_back", credits, 4);

    // fill, then push+pop at full, then an illegal push at full
    for (int i = 0; i < 10; i++) step(credit_m != 0 && i < 4, 8'(8'h30 + i), 0, 0, 0);
    step(0, 0, 1, 1, 8'h77);
    chk("full_pp_head", dout, 8'h31);
    chk("full_pp_vld", dout_vld, 1);
    step(0, 0, 0, 1, 8'h55);
    chk("ovf_set", ovf_err, 1);
    chk("ovf_head_kept", dout, 8'h31);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("ovf_sticky", ovf_err, 1);
    drain_record(6);
    exp4 = '{8'h31, 8'h32, 8'h33, 8'h77};
    chk("full_drain_cnt", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) chk("full_drain_order", seen[i], exp4[i]);
    chk("ovf_still", ovf_err, 1);

    // reset mid-stream with beats buffered and in flight
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("mid_buffered", dout_vld, 1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, 0);
      chk("no_stale", dout_vld, 0);
    end
    chk("mid_credits", credits, 4);

    // randomized traffic with a compliant sender
    do_reset();
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) != 0 && credit_m != 0, 8'($urandom), $urandom_range(0, 3) != 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
    chk("rand_credits_home", credits, 4);
    chk("rand_ovf", ovf_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
